// File: rtl/dct_pkg.sv
// Shared constants and helpers for the 8-point DCT: CW-generic coefficient
// rounding from a Q30 cosine table, butterfly coefficient/sign tables, widths.
package dct_pkg;

  localparam int N = 8;

  function automatic int prod_w(input int iw, input int cw);
    return iw + cw + 2;
  endfunction

  function automatic int acc_w(input int iw, input int cw);
    return iw + cw + 4;
  endfunction

  // cos(k*pi/16) scaled by 2^30
  function automatic longint cos_q30(input int k);
    case (k)
      1:       return 64'sd1053110176;
      2:       return 64'sd992008094;
      3:       return 64'sd892783698;
      4:       return 64'sd759250125;
      5:       return 64'sd596538995;
      6:       return 64'sd410903207;
      7:       return 64'sd209476638;
      default: return 64'sd1073741824;
    endcase
  endfunction

  // ck = round(2^(CW-2) * cos(k*pi/16)), valid for CW up to 30
  function automatic int dct_coef(input int cw, input int k);
    longint v;
    v = (cos_q30(k) + (64'sd1 <<< (31 - cw))) >>> (32 - cw);
    return int'(v);
  endfunction

  // Cosine index used by output k on butterfly term j
  function automatic int coef_idx(input int k, input int j);
    logic [3:0][2:0] t;
    case (k)
      1:       t = {3'd7, 3'd5, 3'd3, 3'd1};
      2:       t = {3'd2, 3'd6, 3'd6, 3'd2};
      3:       t = {3'd5, 3'd1, 3'd7, 3'd3};
      5:       t = {3'd3, 3'd7, 3'd1, 3'd5};
      6:       t = {3'd6, 3'd2, 3'd2, 3'd6};
      7:       t = {3'd1, 3'd3, 3'd5, 3'd7};
      default: t = {3'd4, 3'd4, 3'd4, 3'd4};
    endcase
    return int'(t[j]);
  endfunction

  // Bit j set: term j is subtracted in output k
  function automatic logic [3:0] neg_mask(input int k);
    case (k)
      2:       return 4'b1100;
      3:       return 4'b1110;
      4:       return 4'b0110;
      5:       return 4'b0010;
      6:       return 4'b1010;
      7:       return 4'b1010;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dct_round_sat.sv
// Half-up rounding, arithmetic right shift and narrowing of one accumulator.
// DCT_SAT_EN defined: clamp to the OW-bit signed range; otherwise wrap.
module dct_round_sat #(
  parameter int AW    = 20,
  parameter int SHIFT = 5,
  parameter int OW    = 11
) (
  input  logic signed [AW-1:0] i_acc,
  output logic signed [OW-1:0] o_res
);

  localparam int RW = AW + 1;
  localparam logic signed [RW-1:0] HALF = RW'(2 ** (SHIFT - 1));

  function automatic logic signed [RW-1:0] round_shift(input logic signed [AW-1:0] a);
    return (RW'(a) + HALF) >>> SHIFT;
  endfunction

`ifdef DCT_SAT_EN
  localparam logic signed [RW-1:0] MAXV = RW'(2 ** (OW - 1) - 1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  function automatic logic signed [OW-1:0] narrow(input logic signed [RW-1:0] v);
    if (v > MAXV)      return MAXV[OW-1:0];
    else if (v < MINV) return MINV[OW-1:0];
    else               return v[OW-1:0];
  endfunction
`else
  function automatic logic signed [OW-1:0] narrow(input logic signed [RW-1:0] v);
    return v[OW-1:0];
  endfunction
`endif

  assign o_res = narrow(round_shift(i_acc));

endmodule

// File: rtl/dct_1d_stream.sv
// Three-stage 8-point 1D DCT (butterfly, products, sum/round) with valid/ready.
// DCT_SAT_EN selects clamping instead of wrap on the output coefficients.
module dct_1d_stream
  import dct_pkg::*;
#(
  parameter int IW        = 8,
  parameter int IN_SIGNED = 0,
  parameter int CW        = 8,
  parameter int OW        = 11,
  parameter int SHIFT_DC  = 7,
  parameter int SHIFT_AC  = 5,
  parameter int NOUT      = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [8*IW-1:0] in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [8*OW-1:0] out_data,
  output logic            out_last
);

  localparam int BW = IW + 2;
  localparam int PW = prod_w(IW, CW);
  localparam int AW = acc_w(IW, CW);

  logic w_stall, w_en;
  logic r_vld_p0, r_vld_p1, r_out_valid;
  logic r_last_p0, r_last_p1, r_out_last;
  logic signed [BW-1:0] w_x [N];
  logic signed [BW-1:0] r_p_p0 [4];
  logic signed [BW-1:0] r_m_p0 [4];

  // A held output row freezes every stage; bubbles travel like rows
  assign w_stall   = r_out_valid && !out_ready;
  assign w_en      = !w_stall;
  assign in_ready  = !rst && !w_stall;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

  for (genvar i = 0; i < N; i++) begin : g_ext
    if (IN_SIGNED != 0) begin : g_s
      assign w_x[i] = BW'($signed(in_data[(N-i)*IW-1 -: IW]));
    end else begin : g_u
      assign w_x[i] = $signed(BW'(in_data[(N-i)*IW-1 -: IW]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p0    <= 1'b0;
      r_vld_p1    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_en) begin
      r_vld_p0    <= in_valid;
      r_vld_p1    <= r_vld_p0;
      r_out_valid <= r_vld_p1;
      r_out_last  <= r_last_p1 && r_vld_p1;
    end
  end

  // Stage p0: butterfly sums and differences
  always_ff @(posedge clk) begin
    if (w_en) begin
      for (int j = 0; j < 4; j++) begin
        r_p_p0[j] <= w_x[j] + w_x[N-1-j];
        r_m_p0[j] <= w_x[j] - w_x[N-1-j];
      end
      r_last_p0 <= in_last;
      r_last_p1 <= r_last_p0;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_coef
    if (k < NOUT) begin : g_on
      localparam logic signed [CW-1:0] CV [4] = '{
        CW'(dct_coef(CW, coef_idx(k, 0))), CW'(dct_coef(CW, coef_idx(k, 1))),
        CW'(dct_coef(CW, coef_idx(k, 2))), CW'(dct_coef(CW, coef_idx(k, 3)))};
      localparam logic [3:0] NEG = neg_mask(k);

      logic signed [PW-1:0] r_prod_p1 [4];
      logic signed [AW-1:0] w_acc;
      logic signed [OW-1:0] w_res;
      logic signed [OW-1:0] r_x_p2;

      // Stage p1: even outputs weight the sums, odd outputs the differences
      always_ff @(posedge clk) begin
        if (w_en) begin
          for (int j = 0; j < 4; j++) begin
            if (k % 2 == 0) r_prod_p1[j] <= PW'(r_p_p0[j]) * PW'(CV[j]);
            else            r_prod_p1[j] <= PW'(r_m_p0[j]) * PW'(CV[j]);
          end
        end
      end

      always_comb begin
        w_acc = '0;
        for (int j = 0; j < 4; j++) begin
          if (NEG[j]) w_acc = w_acc - AW'(r_prod_p1[j]);
          else        w_acc = w_acc + AW'(r_prod_p1[j]);
        end
      end

      dct_round_sat #(
        .AW   (AW),
        .SHIFT(k == 0 ? SHIFT_DC : SHIFT_AC),
        .OW   (OW)
      ) u_rs (
        .i_acc(w_acc),
        .o_res(w_res)
      );

      // Stage p2: rounded coefficient held for the output port
      always_ff @(posedge clk) begin
        if (rst)       r_x_p2 <= '0;
        else if (w_en) r_x_p2 <= w_res;
      end

      assign out_data[(N-k)*OW-1 -: OW] = r_x_p2;
    end else begin : g_off
      assign out_data[(N-k)*OW-1 -: OW] = '0;
    end
  end

endmodule

// File: tb/tb_dct_1d_stream.sv
// Scoreboard bench for dct_1d_stream: full-width and NOUT=4 instances share stimulus.
module tb_dct_1d_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_last, out_ready, out_ready4;
  logic [63:0] in_data;
  logic        in_ready, out_valid, out_last;
  logic        in_ready4, out_valid4, out_last4;
  logic [87:0] out_data, out_data4;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  typedef struct packed {
    logic [87:0] data;
    logic        last;
  } exp_t;

  exp_t q[$];
  exp_t q4[$];

  dct_1d_stream #(.IW(8), .IN_SIGNED(0), .CW(8), .OW(11), .SHIFT_DC(7), .SHIFT_AC(5), .NOUT(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last));

  dct_1d_stream #(.IW(8), .IN_SIGNED(0), .CW(8), .OW(11), .SHIFT_DC(7), .SHIFT_AC(5), .NOUT(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .out_last(out_last4));

  // round(64*cos(m*pi/16)) for any m, via quadrant symmetry
  function automatic int cosq(input int m);
    int ct [9];
    int a;
    ct = '{64, 63, 59, 53, 45, 36, 24, 12, 0};
    a = m % 32;
    if (a <= 8)       return ct[a];
    else if (a <= 16) return -ct[16-a];
    else if (a <= 24) return -ct[a-16];
    else              return ct[32-a];
  endfunction

  // Direct-form DCT of one row
  function automatic logic [87:0] model_row(input logic [63:0] din, input int nout);
    logic [87:0] r;
    longint acc, v;
    int sh;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      acc = 0;
      for (int n = 0; n < 8; n++)
        acc += longint'(din[(8-n)*8-1 -: 8]) * (k == 0 ? 45 : cosq((2*n+1)*k));
      sh = (k == 0) ? 7 : 5;
      v = (acc + (longint'(1) <<< (sh - 1))) >>> sh;
`ifdef DCT_SAT_EN
      if (v > 1023) v = 1023;
      else if (v < -1024) v = -1024;
`endif
      if (k < nout) r[(8-k)*11-1 -: 11] = v[10:0];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (in_valid && in_ready)  q.push_back('{model_row(in_data, 8), in_last});
      if (in_valid && in_ready4) q4.push_back('{model_row(in_data, 4), in_last});
      if (out_valid && out_ready) begin
        n_out++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $error("FAIL row_out unexpected observed=%h expected=none", out_data);
        end else begin
          e = q.pop_front();
          assert ({out_data, out_last} === {e.data, e.last}) else begin
            errors++;
            $error("FAIL row_out observed=%h/%b expected=%h/%b", out_data, out_last, e.data, e.last);
          end
        end
      end
      if (out_valid4 && out_ready4) begin
        checks++;
        if (q4.size() == 0) begin
          errors++;
          $error("FAIL row_out4 unexpected observed=%h expected=none", out_data4);
        end else begin
          e = q4.pop_front();
          assert ({out_data4, out_last4} === {e.data, e.last}) else begin
            errors++;
            $error("FAIL row_out4 observed=%h/%b expected=%h/%b", out_data4, out_last4, e.data, e.last);
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input logic [63:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int w = 0; w < 200 && !ok; w++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    check("send_accept", ok, 1);
  endtask

  task automatic wait_out(input string tag);
    bit ok;
    ok = 1'b0;
    for (int w = 0; w < 50 && !ok; w++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
    check({tag, "_seen"}, ok, 1);
  endtask

  task automatic drain();
    for (int w = 0; w < 100 && (q.size() != 0 || q4.size() != 0); w++) tick();
    check("drain_q", q.size(), 0);
    check("drain_q4", q4.size(), 0);
  endtask

  initial begin
    logic [63:0] rows [10];
    int base, stalled;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b1; out_ready4 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_valid4", out_valid4, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    tick();

    send_row({8{8'd128}}, 1'b1);
    in_valid = 1'b0;
    wait_out("flat");
    check("flat_row", out_data, {11'd360, 77'd0});
    check("flat_last", out_last, 1);
    tick();

    send_row({8'd255, 56'd0}, 1'b0);
    in_valid = 1'b0;
    wait_out("impulse");
    check("impulse_x0", out_data[87 -: 11], 11'd90);
    check("impulse_x1", out_data[76 -: 11], 11'd502);
    check("impulse_last", out_last, 0);
    tick();

    send_row({{4{8'd255}}, 32'd0}, 1'b0);
    in_valid = 1'b0;
    wait_out("step");
`ifdef DCT_SAT_EN
    check("step_x1_sat", out_data[76 -: 11], 11'd1023);
`else
    check("step_x1_wrap", out_data[76 -: 11], 11'h51B);
`endif
    tick();
    drain();

    for (int i = 0; i < 10; i++) rows[i] = {$urandom, $urandom};
    base = n_out;
    stalled = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) send_row(rows[i], i == 9);
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          if (out_valid) begin
            stalled++;
            check("stall_in_ready", in_ready, 0);
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_cycles", stalled, 5);
    check("stream_count", n_out - base, 10);

    send_row({$urandom, $urandom}, 1'b0);
    send_row({$urandom, $urandom}, 1'b0);
    send_row({$urandom, $urandom}, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    q.delete();
    q4.delete();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("flush_out_valid", out_valid, 0);
      check("flush_out_valid4", out_valid4, 0);
    end
    tick();
    send_row({8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80}, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1", out_valid, 0);
    @(negedge clk);
    check("lat_cycle2", out_valid, 0);
    @(negedge clk);
    check("lat_cycle3", out_valid, 1);
    tick();
    drain();

    for (int i = 0; i < 20; i++) send_row({$urandom, $urandom}, i[0]);
    in_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
